// File: rtl/jtframe_pll_rstseq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jtframe_pll_rstseq
//  Purpose  : Power-up and lock-recovery reset sequencer for the system PLL.
//             Runs on the PLL reference clock. It pulses the PLL reset,
//             qualifies the (synchronised) lock indication, then releases
//             the SDRAM-side reset, waits for the SDRAM controller, waits a
//             further programmable gap and finally releases the core reset.
//             Loss of lock after release, or a soft request, re-asserts all
//             downstream resets and restarts the PLL.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    refclk     in   PLL reference clock (only clock of this block)
//    rst_n      in   asynchronous active-low reset
//    locked     in   PLL lock, asynchronous (two-flop synchronised here)
//    sdram_rdy  in   SDRAM controller init done, asynchronous (synchronised)
//    soft_req   in   synchronous restart request (pulse or level)
//    pll_rst    out  PLL reset, active high
//    sdram_rst  out  SDRAM domain reset, active high
//    core_rst   out  core domain reset, active high
//    ready      out  high only while the sequence is complete (RUN)
//    st         out  current state encoding
//    retry_cnt  out  number of lock timeouts, saturating at 255
//    loss_cnt   out  number of lock losses after release, saturating at 255
// ============================================================================
module jtframe_pll_rstseq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int SDRAM_DLY    = 256,
    parameter int CORE_DLY     = 4096,
    parameter int CW           = 24
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       sdram_rdy,
    input  logic       soft_req,
    output logic       pll_rst,
    output logic       sdram_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [2:0] st,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        S_PLLRST  = 3'd0,
        S_WAITLK  = 3'd1,
        S_STABLE  = 3'd2,
        S_SDREL   = 3'd3,
        S_SDWAIT  = 3'd4,
        S_COREDLY = 3'd5,
        S_RUN     = 3'd6
    } state_t;

    // The shared counter starts at zero on entry to every state, so a state
    // that must last N cycles leaves when the counter shows N-1.
    localparam logic [CW-1:0] c_pll_last  = CW'(PLL_RST_CYC  - 1);
    localparam logic [CW-1:0] c_to_last   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] c_ls_last   = CW'(LOCK_STABLE  - 1);
    localparam logic [CW-1:0] c_sd_last   = CW'(SDRAM_DLY    - 1);
    localparam logic [CW-1:0] c_core_last = CW'(CORE_DLY     - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [7:0]    c_sat       = 8'hFF;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic r_lk_meta;
    logic r_lk_sync;
    logic r_rdy_meta;
    logic r_rdy_sync;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lk_meta  <= 1'b0;
            r_lk_sync  <= 1'b0;
            r_rdy_meta <= 1'b0;
            r_rdy_sync <= 1'b0;
        end else begin
            r_lk_meta  <= locked;
            r_lk_sync  <= r_lk_meta;
            r_rdy_meta <= sdram_rdy;
            r_rdy_sync <= r_rdy_meta;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state and shared counter
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_retry_inc;
    logic          w_loss_inc;
    logic          w_released;
    logic          w_counting;

    // States from SDREL onward have let at least the SDRAM side out of
    // reset; a lock drop there is a genuine loss and aborts the sequence.
    assign w_released = (r_state == S_SDREL)  || (r_state == S_SDWAIT) ||
                        (r_state == S_COREDLY) || (r_state == S_RUN);

    // SDWAIT and RUN have no time limit, so the counter is parked there.
    assign w_counting = (r_state != S_SDWAIT) && (r_state != S_RUN);

    always_comb begin
        w_next      = r_state;
        w_retry_inc = 1'b0;
        w_loss_inc  = 1'b0;

        if (soft_req) begin
            // Highest priority; leaves both event counters untouched and,
            // while held, pins the sequencer in PLLRST.
            w_next = S_PLLRST;
        end else if (w_released && !r_lk_sync) begin
            w_next     = S_PLLRST;
            w_loss_inc = 1'b1;
        end else begin
            case (r_state)
                S_PLLRST: begin
                    if (r_cnt == c_pll_last) begin
                        w_next = S_WAITLK;
                    end
                end
                S_WAITLK: begin
                    // A lock arriving on the timeout cycle wins.
                    if (r_lk_sync) begin
                        w_next = S_STABLE;
                    end else if (r_cnt == c_to_last) begin
                        w_next      = S_PLLRST;
                        w_retry_inc = 1'b1;
                    end
                end
                S_STABLE: begin
                    // Any low sample restarts the qualification from WAITLK
                    // with a fresh timeout window.
                    if (!r_lk_sync) begin
                        w_next = S_WAITLK;
                    end else if (r_cnt == c_ls_last) begin
                        w_next = S_SDREL;
                    end
                end
                S_SDREL: begin
                    if (r_cnt == c_sd_last) begin
                        w_next = S_SDWAIT;
                    end
                end
                S_SDWAIT: begin
                    if (r_rdy_sync) begin
                        w_next = S_COREDLY;
                    end
                end
                S_COREDLY: begin
                    if (r_cnt == c_core_last) begin
                        w_next = S_RUN;
                    end
                end
                S_RUN: begin
                    w_next = S_RUN;
                end
                default: begin
                    w_next = S_PLLRST;
                end
            endcase
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        // soft_req also clears the count inside PLLRST so that the PLL reset
        // pulse is full length after the request is released.
        if ((w_next != r_state) || soft_req) begin
            w_cnt_next = '0;
        end else if (w_counting) begin
            w_cnt_next = r_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PLLRST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so that they change
    // on the same edge as the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sdram_rst <= 1'b1;
            core_rst  <= 1'b1;
            ready     <= 1'b0;
        end else begin
            pll_rst   <= (w_next == S_PLLRST);
            sdram_rst <= (w_next == S_PLLRST) || (w_next == S_WAITLK) ||
                         (w_next == S_STABLE);
            core_rst  <= (w_next != S_RUN);
            ready     <= (w_next == S_RUN);
        end
    end

    assign st = r_state;

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= 8'd0;
            loss_cnt  <= 8'd0;
        end else begin
            if (w_retry_inc && (retry_cnt != c_sat)) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            if (w_loss_inc && (loss_cnt != c_sat)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
